imem_loader: RTL and testbench

- Boot-time instruction-memory loader for the single-cycle MIPS processor.
- Accepts the program image as a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words.
- Writes each word into instruction memory at consecutive word addresses starting at 0.
- Holds the processor in reset until the image is fully loaded; the IFU then fetches from word 0.

---
 rtl/imem_loader_if.sv | 11 +
 rtl/imem_loader.sv | 88 ++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake carrying the program image into the loader.
// The source drives valid/data/last; the loader answers with ready.
interface imem_loader_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them to
// instruction memory from word 0 and keeps the CPU in reset until the image is in.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_LOAD   | accepting bytes into the assembly register
// S_WRITE  | one-cycle write of the assembled word, stream stalled
// S_DONE   | image complete, CPU released, stream ignored until reset
// S_ERROR  | image larger than memory, CPU held in reset until reset
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_loader_if.slave          src,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE, S_ERROR} state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [31:0] asm_word;
    logic        last_seen;

    assign mem_addr  = word_count[ADDR_WIDTH-1:0];
    assign mem_wdata = asm_word;

    // ready and the status flags are registered alongside the state so nothing
    // on the stream inputs reaches them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LOAD;
            byte_idx   <= 2'd0;
            asm_word   <= 32'd0;
            last_seen  <= 1'b0;
            word_count <= '0;
            src.ready  <= 1'b1;
            mem_we     <= 1'b0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (src.valid && src.ready) begin
                        asm_word  <= asm_word | ({src.data, 24'd0} >> {byte_idx, 3'b000});
                        byte_idx  <= byte_idx + 2'd1;
                        last_seen <= src.last;
                        if (byte_idx == 2'd3 || src.last) begin
                            state     <= S_WRITE;
                            src.ready <= 1'b0;
                            mem_we    <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + 1'b1;
                    byte_idx   <= 2'd0;
                    asm_word   <= 32'd0;
                    mem_we     <= 1'b0;
                    if (last_seen) begin
                        state     <= S_DONE;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                    end else if (&word_count[ADDR_WIDTH-1:0]) begin
                        // memory full but the image continues
                        state <= S_ERROR;
                        error <= 1'b1;
                    end else begin
                        state     <= S_LOAD;
                        src.ready <= 1'b1;
                    end
                end
                S_DONE:  state <= S_DONE;
                S_ERROR: state <= S_ERROR;
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a wide (ADDR_WIDTH=8) and a tiny (ADDR_WIDTH=2)
// instance, each fed images checked against a word-packing reference model.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    imem_loader_if if_a ();
    imem_loader_if if_b ();

    logic        we_a, cr_a, dn_a, er_a;
    logic [7:0]  addr_a;
    logic [31:0] wd_a;
    logic [8:0]  wc_a;

    logic        we_b, cr_b, dn_b, er_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b;
    logic [2:0]  wc_b;

    imem_loader #(.ADDR_WIDTH(8)) u_big (
        .clk(clk), .reset(reset), .src(if_a.slave),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
        .cpu_reset(cr_a), .done(dn_a), .error(er_a), .word_count(wc_a)
    );

    imem_loader #(.ADDR_WIDTH(2)) u_small (
        .clk(clk), .reset(reset), .src(if_b.slave),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
        .cpu_reset(cr_b), .done(dn_b), .error(er_b), .word_count(wc_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    int          hs0[$], hs1[$], wa0[$], wa1[$], wcy0[$], wcy1[$];
    logic [31:0] wdq0[$], wdq1[$];
    int          dc0 = -1, dc1 = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (mon_en && if_a.valid && if_a.ready) hs0.push_back(cyc);
        if (mon_en && if_b.valid && if_b.ready) hs1.push_back(cyc);
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (we_a) begin wa0.push_back(int'(addr_a)); wdq0.push_back(wd_a); wcy0.push_back(cyc); end
            if (we_b) begin wa1.push_back(int'(addr_b)); wdq1.push_back(wd_b); wcy1.push_back(cyc); end
            if (dn_a && dc0 < 0) dc0 = cyc;
            if (dn_b && dc1 < 0) dc1 = cyc;
            if (!dn_a && !er_a) check("ready_vs_we_big", if_a.ready, !we_a);
            if (!dn_b && !er_b) check("ready_vs_we_small", if_b.ready, !we_b);
        end
    end

    task automatic set_in(input int sel, input logic v, input logic [7:0] d, input logic l);
        if (sel == 0) begin
            if_a.valid = v; if_a.data = d; if_a.last = l;
            if_b.valid = 1'b0; if_b.data = 8'h00; if_b.last = 1'b0;
        end else begin
            if_b.valid = v; if_b.data = d; if_b.last = l;
            if_a.valid = 1'b0; if_a.data = 8'h00; if_a.last = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b0;
        set_in(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("rst_ready_big", if_a.ready, 1'b1);
        check("rst_we_big", we_a, 1'b0);
        check("rst_cpu_reset_big", cr_a, 1'b1);
        check("rst_done_big", dn_a, 1'b0);
        check("rst_error_big", er_a, 1'b0);
        check("rst_word_count_big", wc_a, 0);
        check("rst_ready_small", if_b.ready, 1'b1);
        check("rst_cpu_reset_small", cr_b, 1'b1);
        check("rst_word_count_small", wc_b, 0);
        hs0.delete(); hs1.delete(); wa0.delete(); wa1.delete();
        wcy0.delete(); wcy1.delete(); wdq0.delete(); wdq1.delete();
        dc0 = -1; dc1 = -1;
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    // Presents bytes in order, holding each until accepted; stalled cycles carry junk data/last.
    task automatic send_image(input int sel, input logic [7:0] img[$], input bit mark_last,
                              input bit stall, output int accepted);
        int  i = 0;
        int  n = img.size();
        int  budget = 10 * n + 50;
        bit  v;
        logic rdy;
        while (i < n && budget > 0) begin
            @(negedge clk);
            budget--;
            v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (v) set_in(sel, 1'b1, img[i], mark_last && (i == n - 1));
            else   set_in(sel, 1'b0, 8'($urandom), 1'($urandom));
            rdy = (sel == 0) ? if_a.ready : if_b.ready;
            if (v && rdy) i++;
        end
        @(negedge clk);
        set_in(sel, 1'b0, 8'h00, 1'b0);
        accepted = i;
    endtask

    task automatic verify(input string name, input int sel, input logic [7:0] img[$],
                          input int cap, input int accepted);
        int          n, nwords, nexp, lastb, dcy;
        bit          ovf;
        logic [31:0] word;
        int          hs[$], wa[$], wcy[$];
        logic [31:0] wdq[$];
        logic        s_done, s_err, s_cr, s_rdy;
        int          s_wc;

        repeat (3) @(negedge clk);
        if (sel == 0) begin
            hs = hs0; wa = wa0; wcy = wcy0; wdq = wdq0; dcy = dc0;
            s_done = dn_a; s_err = er_a; s_cr = cr_a; s_rdy = if_a.ready; s_wc = int'(wc_a);
        end else begin
            hs = hs1; wa = wa1; wcy = wcy1; wdq = wdq1; dcy = dc1;
            s_done = dn_b; s_err = er_b; s_cr = cr_b; s_rdy = if_b.ready; s_wc = int'(wc_b);
        end

        n = img.size();
        nwords = (n + 3) / 4;
        ovf = nwords > cap;
        nexp = ovf ? cap : nwords;

        check({name, "_accepted"}, accepted, ovf ? 4 * cap : n);
        check({name, "_handshakes"}, hs.size(), ovf ? 4 * cap : n);
        check({name, "_writes"}, wa.size(), nexp);
        for (int w = 0; w < nexp && w < wa.size(); w++) begin
            word = 32'd0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < n) word = word | (32'(img[4 * w + k]) << (24 - 8 * k));
            lastb = (4 * w + 3 < n) ? 4 * w + 3 : n - 1;
            check($sformatf("%s_addr[%0d]", name, w), wa[w], w);
            check($sformatf("%s_wdata[%0d]", name, w), wdq[w], word);
            if (lastb < hs.size())
                check($sformatf("%s_wcycle[%0d]", name, w), wcy[w], hs[lastb] + 1);
        end
        check({name, "_done"}, s_done, !ovf);
        check({name, "_error"}, s_err, ovf);
        check({name, "_cpu_reset"}, s_cr, ovf);
        check({name, "_ready"}, s_rdy, 1'b0);
        check({name, "_word_count"}, s_wc, nexp);
        if (!ovf && wcy.size() > 0)
            check({name, "_done_cycle"}, dcy, wcy[wcy.size() - 1] + 1);
    endtask

    initial begin
        logic [7:0] img[$];
        int acc;
        int len;

        set_in(0, 1'b0, 8'h00, 1'b0);
        do_reset();

        img = '{8'h20, 8'h08, 8'h00, 8'h05};
        send_image(0, img, 1'b1, 1'b0, acc);
        verify("single", 0, img, 256, acc);

        do_reset();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAB};
        send_image(0, img, 1'b1, 1'b0, acc);
        verify("partial", 0, img, 256, acc);

        for (int t = 0; t < 5; t++) begin
            do_reset();
            img.delete();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            send_image(0, img, 1'b1, 1'b1, acc);
            verify($sformatf("rand_big%0d", t), 0, img, 256, acc);
        end

        do_reset();
        img.delete();
        for (int i = 0; i < 17; i++) img.push_back(8'($urandom));
        send_image(1, img, 1'b1, 1'b0, acc);
        verify("overflow", 1, img, 4, acc);

        do_reset();
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
        send_image(1, img, 1'b1, 1'b1, acc);
        verify("exact_fill", 1, img, 4, acc);

        for (int t = 0; t < 4; t++) begin
            do_reset();
            img.delete();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            send_image(1, img, 1'b1, 1'b1, acc);
            verify($sformatf("rand_small%0d", t), 1, img, 4, acc);
        end

        do_reset();
        img.delete();
        for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
        send_image(0, img, 1'b0, 1'b0, acc);
        check("midload_accepted", acc, 6);
        do_reset();
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_image(0, img, 1'b1, 1'b1, acc);
        verify("after_midload", 0, img, 256, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
